// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, branch redirect and one-cycle flush.
// Optional feature: define FETCH_JUMP_EN to redirect on j/jal held in ID.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall,
  input  logic        BranchEQ,
  input  logic        BranchNE,
  input  logic        zero,
  input  logic [31:0] branch_imm,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [5:0]  OP
);

  logic [31:0] pcPlus4;
  logic [31:0] branchTarget;
  logic [31:0] redirectTarget;
  logic        taken;
  logic        jump;
  logic        redirect;

  assign imem_addr    = pc;
  assign OP           = if_id_instr[31:26];
  assign pcPlus4      = pc + 32'd4;
  assign branchTarget = if_id_pc4 + (branch_imm << 2);

  // A bubble in ID carries no decode, so branch inputs are only honoured for a valid word.
  assign taken = if_id_valid & ~stall & ((BranchEQ & zero) | (BranchNE & ~zero));

`ifdef FETCH_JUMP_EN
  logic [31:0] jumpTarget;
  assign jump       = if_id_valid & ~stall & ((OP == 6'h02) | (OP == 6'h03));
  assign jumpTarget = {if_id_pc4[31:28], if_id_instr[25:0], 2'b00};
  // A taken branch outranks a jump decoded in the same cycle.
  assign redirectTarget = taken ? branchTarget : jumpTarget;
`else
  assign jump           = 1'b0;
  assign redirectTarget = branchTarget;
`endif

  assign redirect = taken | jump;

  // IF -> ID register; if_id_pc4 is left untouched on flush and wait since bubbles never use it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc          <= RESET_PC;
      if_id_instr <= '0;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
    end else if (redirect) begin
      pc          <= redirectTarget;
      if_id_instr <= '0;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      if (imem_valid) begin
        pc          <= pcPlus4;
        if_id_instr <= imem_rdata;
        if_id_pc4   <= pcPlus4;
        if_id_valid <= 1'b1;
      end else begin
        if_id_instr <= '0;
        if_id_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand sequences, then random stimulus vs a rule model.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_valid = 1'b1;
  logic        stall = 1'b0;
  logic        BranchEQ = 1'b0;
  logic        BranchNE = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] branch_imm = '0;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [5:0]  OP;

  int nChecks = 0;
  int nFail = 0;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .imem_valid(imem_valid), .stall(stall), .BranchEQ(BranchEQ), .BranchNE(BranchNE),
    .zero(zero), .branch_imm(branch_imm), .pc(pc), .if_id_instr(if_id_instr),
    .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid), .OP(OP)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        iv;
    logic [31:0] rdata;
    logic        beq;
    logic        bne;
    logic        zero;
    logic [31:0] imm;
    logic [31:0] ePc;
    logic [31:0] eInstr;
    logic [31:0] ePc4;
    logic        pc4Chk;
    logic        eValid;
  } vec_t;

  vec_t vecs[$];

  // Reference state, advanced by the architectural rules once per rising edge.
  logic [31:0] mPc, mInstr, mPc4;
  logic        mValid, mPc4Known;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic addVec(input logic st, input logic iv, input logic [31:0] rd, input logic beq,
                        input logic bne, input logic z, input logic [31:0] imm,
                        input logic [31:0] ePc, input logic [31:0] eInstr,
                        input logic [31:0] ePc4, input logic pc4Chk, input logic eValid);
    vec_t v;
    v.stall = st; v.iv = iv; v.rdata = rd; v.beq = beq; v.bne = bne; v.zero = z; v.imm = imm;
    v.ePc = ePc; v.eInstr = eInstr; v.ePc4 = ePc4; v.pc4Chk = pc4Chk; v.eValid = eValid;
    vecs.push_back(v);
  endtask

  task automatic modelStep();
    logic        redir;
    logic [31:0] target;
    logic [5:0]  op;
    if (!reset) begin
      mPc = RST_PC; mInstr = '0; mPc4 = '0; mValid = 1'b0; mPc4Known = 1'b1;
      return;
    end
    redir  = 1'b0;
    target = '0;
    op     = mInstr[31:26];
    if (mValid && !stall) begin
      if ((BranchEQ && zero) || (BranchNE && !zero)) begin
        redir  = 1'b1;
        target = mPc4 + branch_imm * 32'd4;
      end
`ifdef FETCH_JUMP_EN
      else if (op == 6'h02 || op == 6'h03) begin
        redir  = 1'b1;
        target = {mPc4[31:28], mInstr[25:0], 2'b00};
      end
`endif
    end
    if (redir) begin
      mPc = target; mInstr = '0; mValid = 1'b0; mPc4Known = 1'b0;
    end else if (stall) begin
      // everything holds
    end else if (imem_valid) begin
      mInstr = imem_rdata; mPc4 = mPc + 32'd4; mPc = mPc + 32'd4;
      mValid = 1'b1; mPc4Known = 1'b1;
    end else begin
      mInstr = '0; mValid = 1'b0; mPc4Known = 1'b0;
    end
  endtask

  task automatic compareModel(input string tag);
    logic [5:0] eOp;
    eOp = mInstr[31:26];
    check({tag, "_pc"}, pc, mPc);
    check({tag, "_addr"}, imem_addr, mPc);
    check({tag, "_instr"}, if_id_instr, mInstr);
    check({tag, "_valid"}, {31'b0, if_id_valid}, {31'b0, mValid});
    check({tag, "_op"}, {26'b0, OP}, {26'b0, eOp});
    if (mPc4Known) check({tag, "_pc4"}, if_id_pc4, mPc4);
  endtask

  task automatic cycle(input string tag);
    modelStep();
    @(posedge clk);
    #1;
    compareModel(tag);
  endtask

  task automatic setIn(input logic st, input logic iv, input logic [31:0] rd, input logic beq,
                       input logic bne, input logic z, input logic [31:0] imm);
    stall = st; imem_valid = iv; imem_rdata = rd; BranchEQ = beq; BranchNE = bne;
    zero = z; branch_imm = imm;
  endtask

  function automatic logic [31:0] wordA(input int k);
    return 32'h8C00_0000 | k;
  endfunction

  initial begin
    logic [31:0] diff, imm;
    logic [31:0] jWord;
    vec_t v;
    logic [5:0] eOp;

    // Reset asserted before any clock edge must take effect asynchronously.
    #1 reset = 1'b0;
    #2;
    check("rst_pc", pc, RST_PC);
    check("rst_addr", imem_addr, RST_PC);
    check("rst_instr", if_id_instr, 32'h0);
    check("rst_pc4", if_id_pc4, 32'h0);
    check("rst_valid", {31'b0, if_id_valid}, 32'h0);
    @(posedge clk); #1;
    check("rst_hold_pc", pc, RST_PC);
    @(negedge clk);
    reset = 1'b1;

    addVec(0, 1, wordA(0), 0, 0, 0, 0, 32'h0040_0004, wordA(0), 32'h0040_0004, 1, 1);
    addVec(0, 1, wordA(1), 0, 0, 0, 0, 32'h0040_0008, wordA(1), 32'h0040_0008, 1, 1);
    addVec(0, 1, wordA(2), 0, 0, 0, 0, 32'h0040_000C, wordA(2), 32'h0040_000C, 1, 1);
    addVec(0, 1, wordA(3), 0, 0, 0, 0, 32'h0040_0010, wordA(3), 32'h0040_0010, 1, 1);
    addVec(0, 1, wordA(4), 1, 0, 1, 32'hFFFF_FFFE, 32'h0040_0008, 32'h0, 32'h0, 0, 0);
    addVec(0, 1, wordA(5), 1, 0, 1, 32'hFFFF_FFFE, 32'h0040_000C, wordA(5), 32'h0040_000C, 1, 1);
    addVec(0, 1, wordA(6), 0, 1, 1, 32'hFFFF_FFFE, 32'h0040_0010, wordA(6), 32'h0040_0010, 1, 1);
    addVec(1, 1, wordA(7), 1, 0, 1, 32'h0000_0010, 32'h0040_0010, wordA(6), 32'h0040_0010, 1, 1);
    addVec(1, 1, wordA(7), 0, 0, 0, 0, 32'h0040_0010, wordA(6), 32'h0040_0010, 1, 1);
    addVec(1, 1, wordA(7), 0, 0, 0, 0, 32'h0040_0010, wordA(6), 32'h0040_0010, 1, 1);
    addVec(0, 1, wordA(8), 0, 0, 0, 0, 32'h0040_0014, wordA(8), 32'h0040_0014, 1, 1);
    addVec(0, 0, wordA(9), 0, 0, 0, 0, 32'h0040_0014, 32'h0, 32'h0, 0, 0);
    addVec(0, 0, wordA(9), 0, 0, 0, 0, 32'h0040_0014, 32'h0, 32'h0, 0, 0);
    addVec(0, 1, wordA(9), 0, 0, 0, 0, 32'h0040_0018, wordA(9), 32'h0040_0018, 1, 1);
    addVec(0, 1, wordA(10), 0, 1, 0, 32'h0000_0004, 32'h0040_0028, 32'h0, 32'h0, 0, 0);
    addVec(0, 1, wordA(11), 0, 0, 0, 0, 32'h0040_002C, wordA(11), 32'h0040_002C, 1, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      setIn(v.stall, v.iv, v.rdata, v.beq, v.bne, v.zero, v.imm);
      @(posedge clk); #1;
      eOp = v.eInstr[31:26];
      check($sformatf("vec%0d_pc", i), pc, v.ePc);
      check($sformatf("vec%0d_addr", i), imem_addr, v.ePc);
      check($sformatf("vec%0d_instr", i), if_id_instr, v.eInstr);
      check($sformatf("vec%0d_valid", i), {31'b0, if_id_valid}, {31'b0, v.eValid});
      check($sformatf("vec%0d_op", i), {26'b0, OP}, {26'b0, eOp});
      if (v.pc4Chk) check($sformatf("vec%0d_pc4", i), if_id_pc4, v.ePc4);
    end

    mPc = 32'h0040_002C; mInstr = wordA(11); mPc4 = 32'h0040_002C;
    mValid = 1'b1; mPc4Known = 1'b1;

    // Branch to just below the top of the address space, then fetch across the wrap.
    diff = 32'hFFFF_FFF8 - 32'h0040_002C;
    imm  = 32'($signed(diff) >>> 2);
    setIn(0, 1, wordA(12), 1, 0, 1, imm);
    cycle("wrapbr");
    check("wrapbr_pc_const", pc, 32'hFFFF_FFF8);
    setIn(0, 1, wordA(13), 0, 0, 0, 0);
    cycle("wrap1");
    check("wrap1_pc_const", pc, 32'hFFFF_FFFC);
    jWord = {6'h02, 26'h010_0000};
    setIn(0, 1, jWord, 0, 0, 0, 0);
    cycle("wrap2");
    check("wrap2_pc_const", pc, 32'h0000_0000);
    check("wrap2_pc4_const", if_id_pc4, 32'h0000_0000);
    setIn(0, 1, wordA(14), 0, 0, 0, 0);
    cycle("jmp");
`ifdef FETCH_JUMP_EN
    check("jmp_pc_const", pc, 32'h0040_0000);
    check("jmp_valid_const", {31'b0, if_id_valid}, 32'h0);
`else
    check("nojmp_pc_const", pc, 32'h0000_0004);
    check("nojmp_instr_const", if_id_instr, wordA(14));
`endif

    // Branch and jump together in ID: the branch must win.
    setIn(0, 1, {6'h03, 26'h010_0010}, 0, 0, 0, 0);
    cycle("prio_ld");
    setIn(0, 1, wordA(15), 1, 0, 1, 32'h0000_0001);
    cycle("prio");
`ifdef FETCH_JUMP_EN
    check("prio_pc_const", pc, 32'h0040_0008);
`else
    check("prio_pc_const", pc, 32'h0000_000C);
`endif
    setIn(0, 1, wordA(16), 0, 0, 0, 0);
    cycle("prio_after");

    // Reset in the middle of a stall with a taken-looking branch pending.
    setIn(1, 1, wordA(17), 1, 0, 1, 32'h0000_0040);
    cycle("prestall");
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst_pc", pc, RST_PC);
    check("midrst_valid", {31'b0, if_id_valid}, 32'h0);
    check("midrst_instr", if_id_instr, 32'h0);
    cycle("midrst_hold");
    @(negedge clk);
    reset = 1'b1;
    setIn(0, 1, wordA(18), 0, 0, 0, 0);
    cycle("postrst");
    check("postrst_pc_const", pc, 32'h0040_0004);
    check("postrst_instr_const", if_id_instr, wordA(18));

    for (int i = 0; i < 400; i++) begin
      logic [31:0] rd;
      rd = $urandom;
      if ($urandom_range(0, 3) == 0) rd[31:26] = 6'h02 + 6'($urandom_range(0, 1));
      setIn($urandom_range(0, 4) == 0, $urandom_range(0, 4) != 0, rd,
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
            32'($signed($urandom_range(0, 63)) - 32));
      reset = ($urandom_range(0, 99) != 0);
      cycle($sformatf("rnd%0d", i));
    end
    reset = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0040_0000, first instruction address after reset.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port imem_addr  output  32  instruction memory byte address, equal to pc.
REQ-005 SHALL have port imem_rdata  input  32  instruction word at imem_addr.
REQ-006 SHALL have port imem_valid  input  1  imem_rdata valid this cycle.
REQ-007 SHALL have port stall  input  1  hazard hold request from ID.
REQ-008 SHALL have port BranchEQ  input  1  branch-if-equal decode of the ID instruction.
REQ-009 SHALL have port BranchNE  input  1  branch-if-not-equal decode of the ID instruction.
REQ-010 SHALL have port zero  input  1  ALU zero flag for the ID branch compare.
REQ-011 SHALL have port branch_imm  input  32  sign-extended immediate of the ID instruction.
REQ-012 SHALL have port pc  output  32  current fetch address.
REQ-013 SHALL have port if_id_instr  output  32  registered instruction presented to ID.
REQ-014 SHALL have port if_id_pc4  output  32  registered fetch address + 4 of that instruction.
REQ-015 SHALL have port if_id_valid  output  1  if_id_instr is a real instruction, not a bubble.
REQ-016 SHALL have port OP  output  6  if_id_instr[31:26], combinational, feeds the control unit.

Function
REQ-017 SHALL compute taken = if_id_valid & ~stall & ((BranchEQ & zero) | (BranchNE & ~zero)).
REQ-018 SHALL compute branch target = if_id_pc4 + (branch_imm << 2), modulo 2^32.
REQ-019 SHALL apply per-edge priority: redirect (taken or jump), then stall, then fetch, then memory wait.
REQ-020 On redirect: pc <= target; if_id_instr <= 0; if_id_valid <= 0 (one-cycle flush of the wrong-path word).
REQ-021 On stall without redirect: pc, if_id_instr, if_id_pc4, if_id_valid all hold.
REQ-022 On fetch (imem_valid=1, no stall, no redirect): if_id_instr <= imem_rdata; if_id_pc4 <= pc+4; if_id_valid <= 1; pc <= pc+4.
REQ-023 On memory wait (imem_valid=0, no stall, no redirect): pc holds; if_id_instr <= 0; if_id_valid <= 0.
REQ-024 SHALL wrap pc+4 modulo 2^32 (32'hFFFF_FFFC advances to 32'h0000_0000).
REQ-025 SHALL keep imem_addr equal to pc at all times, zero latency.
REQ-026 Bubbles SHALL carry instruction 32'h0000_0000 (sll $0 nop), so OP = 0 during bubbles.
REQ-027 SHALL ignore BranchEQ/BranchNE/zero when if_id_valid=0.

Reset
REQ-028 While reset=0: pc = RESET_PC, if_id_instr = 0, if_id_pc4 = 0, if_id_valid = 0, asynchronously.
REQ-029 Reset asserted mid-redirect or mid-stall SHALL override both; first fetch after release is from RESET_PC.

Configuration
REQ-030 With macro FETCH_JUMP_EN defined, if_id_valid=1, ~stall and OP = 6'h02 (j) or 6'h03 (jal) SHALL redirect to {if_id_pc4[31:28], if_id_instr[25:0], 2'b00} with flush per REQ-020.
REQ-031 Without FETCH_JUMP_EN, opcodes 6'h02/6'h03 SHALL cause no redirect; pc advances sequentially.
REQ-032 With FETCH_JUMP_EN defined, a simultaneous branch taken SHALL take priority over the jump.

Verification
REQ-033 Reset release, imem_valid=1 constant -> pc = 0x00400000, 0x00400004, 0x00400008 on consecutive edges; if_id_valid rises one cycle after release.
REQ-034 ID holds beq (BranchEQ=1, zero=1, branch_imm=-2, if_id_pc4=0x00400010) -> next pc = 0x00400008, if_id_valid=0 for one cycle.
REQ-035 Same with BranchNE=1, zero=1 -> no redirect, pc advances by 4.
REQ-036 stall=1 for 3 cycles with imem_valid=1 -> pc and if_id_* unchanged for 3 edges, resume at same pc.
REQ-037 imem_valid=0 for 2 cycles -> pc holds, if_id_valid=0, OP=0, then fetch resumes.
REQ-038 pc forced near 0xFFFFFFFC, fetch -> pc = 0x00000000; with FETCH_JUMP_EN, j 0x0100000 in ID -> pc = 0x00400000.
